// File: rtl/ssd_pkg.sv
// Shared types, segment constants and elaboration helpers for the
// seven-segment scan driver and its sequential binary-to-BCD converter.
package ssd_pkg;

  // Converter state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  // Segment patterns {a,b,c,d,e,f,g}, active-low
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;

  // Nibble to segment pattern; 10..15 cannot occur in a valid BCD digit
  // and fall back to the "0" pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_ZERO;
    endcase
    return seg;
  endfunction

  // 10^n, evaluated at elaboration
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Nibbles needed in the double-dabble accumulator: at least one per
  // displayed digit, and enough to hold 2^num_w - 1 without truncation.
  function automatic int acc_nibbles(input int num_w, input int digits);
    logic [63:0] max_v;
    int          n;
    max_v = (64'd1 << num_w) - 64'd1;
    n     = 1;
    for (int k = 1; k < 20; k++) begin
      if (pow10(k) <= max_v) n = k + 1;
    end
    return (n > digits) ? n : digits;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, NUM_W
// shift cycles followed by a single COMMIT cycle in which bcd/ovf are
// valid for the consumer to capture.
//
// state  | meaning
// IDLE   | ready for a new value; start captures bin
// SHIFT  | add-3 adjust then shift, one bit per cycle
// COMMIT | result stable on bcd/ovf, valid high for one cycle
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int NUM_W  = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_W-1:0]      bin,
  output logic                  ready,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  ovf,
  output logic                  valid
);

  localparam int          ACC_N = acc_nibbles(NUM_W, DIGITS);
  localparam int          ACC_W = ACC_N * 4;
  localparam int          CNT_W = $clog2(NUM_W + 1);
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

  conv_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] adj;
  logic [NUM_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SHIFT;
      ST_SHIFT:  if (cnt_q == CNT_W'(1)) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready = (state_q == ST_IDLE);
    valid = (state_q == ST_COMMIT);
  end

  // Datapath registers: accumulator, shift register, bit count, overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Datapath next values; overflow is decided once from the raw input
  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    adj   = acc_q;
    for (int i = 0; i < ACC_N; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          sh_d  = bin;
          cnt_d = CNT_W'(NUM_W);
          ovf_d = (64'(bin) > LIMIT);
        end
      end
      ST_SHIFT: begin
        acc_d = {adj[ACC_W-2:0], sh_q[NUM_W-1]};
        sh_d  = {sh_q[NUM_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign bcd = acc_q[DIGITS*4-1:0];
  assign ovf = ovf_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// Seven-segment scan driver: accepts values through a load/ready
// handshake, converts them with bin2bcd_seq, holds the shown value in a
// display register and multiplexes the digits MSB first.
// Optional build macro SSD_SIGNED_EN: treat num as two's complement and
// show a minus sign (magnitude limited to DIGITS-1 digits for negatives).
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_W    = 13,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 262144
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_W-1:0]   num,
  input  logic               load,
  input  logic               blank_lz,
  output logic               ready,
  output logic [DIGITS-1:0]  anode,
  output logic [6:0]         led_out
);

  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DISP_W = DIGITS * 4;

  logic              conv_ready;
  logic              conv_valid;
  logic              conv_ovf;
  logic [DISP_W-1:0] conv_bcd;
  logic [NUM_W-1:0]  conv_bin;
  logic              accept;

  logic              pend_blank_q, pend_blank_d;
  logic [DISP_W-1:0] disp_bcd_q, disp_bcd_d;
  logic              disp_ovf_q, disp_ovf_d;
  logic              disp_blank_q, disp_blank_d;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  msd;
  logic [3:0]        cur_nib;

  assign accept = load & conv_ready;
  assign ready  = conv_ready;

`ifdef SSD_SIGNED_EN
  logic             pend_neg_q, pend_neg_d;
  logic             disp_neg_q, disp_neg_d;
  logic [IDX_W:0]   minus_pos;

  // Converter always sees the magnitude; the most negative value maps to
  // 2^(NUM_W-1), which is still representable as NUM_W-bit unsigned.
  assign conv_bin = num[NUM_W-1] ? (-num) : num;
`else
  assign conv_bin = num;
`endif

  bin2bcd_seq #(
    .NUM_W  (NUM_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .bin   (conv_bin),
    .ready (conv_ready),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf),
    .valid (conv_valid)
  );

  // Side-band flags captured with the accepted value, held until commit
  always_comb begin
    pend_blank_d = pend_blank_q;
    if (accept) pend_blank_d = blank_lz;
  end

`ifdef SSD_SIGNED_EN
  // Sign captured alongside the blank flag
  always_comb begin
    pend_neg_d = pend_neg_q;
    if (accept) pend_neg_d = num[NUM_W-1];
  end
`endif

  // Display register loads only on the converter's commit cycle
  always_comb begin
    disp_bcd_d   = disp_bcd_q;
    disp_ovf_d   = disp_ovf_q;
    disp_blank_d = disp_blank_q;
`ifdef SSD_SIGNED_EN
    disp_neg_d   = disp_neg_q;
`endif
    if (conv_valid) begin
      disp_bcd_d   = conv_bcd;
      disp_ovf_d   = conv_ovf;
      disp_blank_d = pend_blank_q;
`ifdef SSD_SIGNED_EN
      // A negative value gives up the top digit to the minus sign
      disp_neg_d   = pend_neg_q;
      disp_ovf_d   = conv_ovf | (pend_neg_q & (conv_bcd[DISP_W-1 -: 4] != 4'd0));
`endif
    end
  end

  // Pending flags and display register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_blank_q <= 1'b0;
      disp_bcd_q   <= '0;
      disp_ovf_q   <= 1'b0;
      disp_blank_q <= 1'b0;
`ifdef SSD_SIGNED_EN
      pend_neg_q   <= 1'b0;
      disp_neg_q   <= 1'b0;
`endif
    end else begin
      pend_blank_q <= pend_blank_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_ovf_q   <= disp_ovf_d;
      disp_blank_q <= disp_blank_d;
`ifdef SSD_SIGNED_EN
      pend_neg_q   <= pend_neg_d;
      disp_neg_q   <= disp_neg_d;
`endif
    end
  end

  // Prescaler and digit index; index steps down from the MSB digit
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == '0) ? IDX_W'(DIGITS - 1) : idx_q - IDX_W'(1);
    end
  end

  // Scan registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= IDX_W'(DIGITS - 1);
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Active-low one-hot digit enable
  always_comb begin
    anode = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) anode[i] = 1'b0;
    end
  end

  // Most significant nonzero digit (0 when the value is zero) and the
  // nibble of the digit currently being driven
  always_comb begin
    msd     = '0;
    cur_nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_bcd_q[i*4 +: 4] != 4'd0) msd = IDX_W'(i);
      if (idx_q == IDX_W'(i)) cur_nib = disp_bcd_q[i*4 +: 4];
    end
  end

  // Segment pattern: decode, then blanking, sign, and overflow override
  always_comb begin
    led_out = seg_decode(cur_nib);
    if (disp_blank_q && (idx_q > msd)) led_out = SEG_BLANK;
`ifdef SSD_SIGNED_EN
    minus_pos = disp_blank_q ? ({1'b0, msd} + (IDX_W+1)'(1)) : (IDX_W+1)'(DIGITS - 1);
    if (disp_neg_q && ({1'b0, idx_q} == minus_pos)) led_out = SEG_MINUS;
`endif
    if (disp_ovf_q) led_out = SEG_DASH;
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

  localparam int NUM_W    = 14;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S_DA = 7'b1111110;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_W-1:0]  num = '0;
  logic              load = 1'b0;
  logic              blank_lz = 1'b0;
  logic              ready;
  logic [DIGITS-1:0] anode;
  logic [6:0]        led_out;

  always #5 clk = ~clk;

  ssd_scan_driver #(
    .NUM_W    (NUM_W),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .num      (num),
    .load     (load),
    .blank_lz (blank_lz),
    .ready    (ready),
    .anode    (anode),
    .led_out  (led_out)
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Cycles since reset, for the expected scan position
  int n_scan;
  always @(posedge clk or posedge rst) begin
    if (rst) n_scan <= 0;
    else     n_scan <= n_scan + 1;
  end

  // Reference: a load is accepted when idle, the value shows NUM_W+1 cycles later
  int               m_left;
  logic [NUM_W-1:0] m_pend_val, m_show_val;
  logic             m_pend_bl, m_show_bl;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left     <= 0;
      m_pend_val <= '0;
      m_show_val <= '0;
      m_pend_bl  <= 1'b0;
      m_show_bl  <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_show_val <= m_pend_val;
        m_show_bl  <= m_pend_bl;
      end
    end else if (load) begin
      m_pend_val <= num;
      m_pend_bl  <= blank_lz;
      m_left     <= NUM_W + 1;
    end
  end

  function automatic int pow10i(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input int d, input logic [NUM_W-1:0] v, input logic bl);
    int mag;
    int p;
    mag = int'(v);
`ifdef SSD_SIGNED_EN
    begin
      int ndig;
      int mpos;
      if (v[NUM_W-1]) begin
        mag = (1 << NUM_W) - int'(v);
        if (mag > pow10i(DIGITS-1) - 1) return S_DA;
        ndig = 1;
        while (pow10i(ndig) <= mag) ndig++;
        mpos = bl ? ndig : DIGITS - 1;
        if (d == mpos) return S_DA;
      end
    end
`endif
    if (mag > pow10i(DIGITS) - 1) return S_DA;
    p = pow10i(d);
    if (bl && d > 0 && mag < p) return S_BL;
    return SEG_TAB[(mag / p) % 10];
  endfunction

  function automatic int exp_idx();
    return DIGITS - 1 - ((n_scan / SCAN_DIV) % DIGITS);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare against the reference
  task automatic tick();
    int idx;
    logic [DIGITS-1:0] ea;
    @(negedge clk);
    if (chk_en) begin
      idx = exp_idx();
      ea = '1;
      ea[idx] = 1'b0;
      check("ready", int'(ready), int'(m_left == 0));
      check("anode", int'(anode), int'(ea));
      check("led_out", int'(led_out), int'(model_seg(idx, m_show_val, m_show_bl)));
    end
  endtask

  task automatic do_load(input logic [NUM_W-1:0] v, input logic b);
    int w = 0;
    while (m_left != 0 && w < 100) begin
      tick();
      w++;
    end
    check("load_wait", int'(w < 100), 1);
    num = v;
    blank_lz = b;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  typedef struct {
    logic [NUM_W-1:0] v;
    logic             bl;
    logic [3:0][6:0]  seg;
  } vec_t;

  function automatic vec_t mk(input logic [NUM_W-1:0] v, input logic bl,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    vec_t r;
    r.v = v;
    r.bl = bl;
    r.seg = {s3, s2, s1, s0};
    return r;
  endfunction

  // Check one full frame against fixed expected patterns
  task automatic frame_const(input string name, input logic [3:0][6:0] seg);
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      tick();
      check(name, int'(led_out), int'(seg[exp_idx()]));
    end
  endtask

  vec_t vecs[$];

  initial begin
    int lowc;
    int w;
    logic [3:0][6:0] e1234;
    e1234 = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};

`ifdef SSD_SIGNED_EN
    vecs.push_back(mk(14'h3FD6, 1'b1, S_BL, S_DA, 7'b1001100, 7'b0010010));
    vecs.push_back(mk(14'h3C18, 1'b0, S_DA, S_DA, S_DA, S_DA));
    vecs.push_back(mk(14'h3C19, 1'b0, S_DA, 7'b0000100, 7'b0000100, 7'b0000100));
    vecs.push_back(mk(14'h3FFB, 1'b0, S_DA, 7'b0000001, 7'b0000001, 7'b0100100));
    vecs.push_back(mk(14'h3FFB, 1'b1, S_BL, S_BL, S_DA, 7'b0100100));
    vecs.push_back(mk(14'h2000, 1'b0, S_DA, S_DA, S_DA, S_DA));
    vecs.push_back(mk(14'd42,   1'b1, S_BL, S_BL, 7'b1001100, 7'b0010010));
    vecs.push_back(mk(14'd8191, 1'b0, 7'b0000000, 7'b1001111, 7'b0000100, 7'b1001111));
    vecs.push_back(mk(14'd0,    1'b1, S_BL, S_BL, S_BL, 7'b0000001));
`else
    vecs.push_back(mk(14'd1234,  1'b0, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100));
    vecs.push_back(mk(14'd7,     1'b1, S_BL, S_BL, S_BL, 7'b0001111));
    vecs.push_back(mk(14'd0,     1'b1, S_BL, S_BL, S_BL, 7'b0000001));
    vecs.push_back(mk(14'd0,     1'b0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001));
    vecs.push_back(mk(14'd12000, 1'b0, S_DA, S_DA, S_DA, S_DA));
    vecs.push_back(mk(14'd9999,  1'b0, 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100));
    vecs.push_back(mk(14'd10000, 1'b1, S_DA, S_DA, S_DA, S_DA));
    vecs.push_back(mk(14'd105,   1'b1, S_BL, 7'b1001111, 7'b0000001, 7'b0100100));
    vecs.push_back(mk(14'd16383, 1'b0, S_DA, S_DA, S_DA, S_DA));
    vecs.push_back(mk(14'd8,     1'b0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000000));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_anode", int'(anode), int'(4'b0111));
    check("rst_led", int'(led_out), int'(7'b0000001));
    rst = 1'b0;
    chk_en = 1'b1;
    frame_const("rst_frame", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001});

    // Load-to-ready latency, then a back-to-back load
    do_load(14'd1234, 1'b0);
    lowc = 0;
    w = 0;
    while (ready == 1'b0 && w < 60) begin
      lowc++;
      tick();
      w++;
    end
    check("ready_low_cycles", lowc, NUM_W + 1);
    frame_const("show_1234", e1234);
    do_load(14'd1234, 1'b0);
    check("b2b_busy", int'(ready), 0);
    repeat (NUM_W + 1) tick();

    // Table of values with fixed expected patterns
    foreach (vecs[i]) begin
      do_load(vecs[i].v, vecs[i].bl);
      repeat (NUM_W + 1) tick();
      frame_const($sformatf("vec%0d", i), vecs[i].seg);
    end

    // Load during conversion is ignored
    do_load(14'd1234, 1'b0);
    repeat (3) tick();
    check("busy_mid", int'(ready), 0);
    num = 14'd987;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (NUM_W + 2) tick();
    frame_const("ignored_load", e1234);

    // Asynchronous reset in the middle of a conversion
    do_load(14'd4321, 1'b0);
    repeat (4) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready", int'(ready), 1);
    check("arst_anode", int'(anode), int'(4'b0111));
    check("arst_led", int'(led_out), int'(7'b0000001));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NUM_W + 4 + DIGITS * SCAN_DIV; k++) begin
      tick();
      check("no_commit", int'(led_out), int'(7'b0000001));
    end

    // Random traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      load = ($urandom_range(0, 3) == 0);
      blank_lz = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0:       num = NUM_W'($urandom_range(0, 99));
        1:       num = NUM_W'($urandom_range(0, 10999));
        default: num = NUM_W'($urandom);
      endcase
      tick();
    end
    load = 1'b0;
    repeat (NUM_W + 2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised seven-segment display driver for the board I/O path. It converts a binary value to BCD with a sequential double-dabble engine, one bit per cycle, and accepts new values through a load/ready handshake. It time-multiplexes a configurable number of digits, with leading-zero blanking and overflow indication. It sits between the processor's display register and the board's SSD pins.

## Interface
- `NUM_W`, 13, binary input width (≥4)
- `DIGITS`, 4, number of display digits (1–8)
- `SCAN_DIV`, 262144, clock cycles each digit stays active (≥2)
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `num`  in  NUM_W  binary value, sampled only on an accepted load
- `load`  in  1  request conversion of `num`
- `blank_lz`  in  1  1 = blank leading zeros; sampled with `num`
- `ready`  out  1  converter idle, load will be accepted
- `anode`  out  DIGITS  digit enables, active-low; bit DIGITS-1 = most significant digit
- `led_out`  out  7  segments {a,b,c,d,e,f,g}, active-low ("0" = 7'b0000001)

## Operation
- Converter FSM has three states:
  - IDLE: `ready`=1. `load`=1 captures `num`/`blank_lz`, clears the BCD accumulator, sets bit count = NUM_W, and moves to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, shreg} left 1. Decrement count; when the count reaches 0, move to COMMIT.
  - COMMIT: write the BCD digits, overflow flag and blank flag to the display register. Go to IDLE.
- Accumulator width is DIGITS×4 plus enough extra nibbles to hold 2^NUM_W−1.
- Overflow: set when value > 10^DIGITS−1 (constant computed at elaboration). When set, every digit shows dash 7'b1111110.
- `load` while not `ready` is ignored; no queueing. The display register changes only in COMMIT, so the old value stays shown during conversion.
- Scan:
  - Prescaler counts 0..SCAN_DIV−1. On wrap, digit index advances DIGITS−1 → … → 0 → DIGITS−1 (MSB first).
  - `anode` has exactly one bit low: the bit at the current digit index.
- Blanking: with the blank flag set, zero digits above the most significant nonzero digit output 7'b1111111. Digit 0 is never blanked, so value 0 shows "0".
- Decode: nibble 0–9 uses the standard patterns. Nibbles 10–15 are unreachable; they decode to "0".
- `led_out` and `anode` are combinational from registered state only, never from `num`.

## Timing
- Load accepted at edge t:
  - `ready`=0 from t to t+NUM_W+1.
  - SHIFT occupies NUM_W cycles.
  - Display register updates at edge t+NUM_W+1.
  - `ready`=1 after edge t+NUM_W+1 (load-to-ready NUM_W+1 cycles).
- Back-to-back: a load at the first `ready` edge is accepted, with no dead cycle.
- Reset, asserted any time including mid-conversion, takes effect immediately:
  - FSM to IDLE, `ready`=1
  - Display register = 0 with blank flag cleared, so "0000" is shown
  - Prescaler = 0, digit index = DIGITS−1
  - `anode` = only MSB low, `led_out` = 7'b0000001
- A partially converted value is never committed after reset.
- Digit period = SCAN_DIV cycles. Full frame = DIGITS×SCAN_DIV cycles. The scan is unaffected by conversions.

## Configuration
- `SSD_SIGNED_EN` defined:
  - `num` is two's complement; the engine converts |num| (NUM_W-bit unsigned, so the most negative value works).
  - Negative values show minus 7'b1111110 in the MSB digit.
  - Magnitude limit is 10^(DIGITS−1)−1; beyond it, overflow dashes are shown.
  - With blanking enabled, the minus moves to the digit just left of the most significant shown digit.
- Undefined: `num` is unsigned, there is no sign logic, and the limit is 10^DIGITS−1.

## Structure
- Package `ssd_pkg`:
  - Converter state encoding (IDLE/SHIFT/COMMIT)
  - Segment constants SEG_BLANK, SEG_DASH, SEG_MINUS
  - `seg_decode` function (nibble → 7 bits)
  - `pow10` elaboration function
- Sub-module `bin2bcd_seq` holds the converter FSM and accumulator, with ports clk, rst, start, bin, ready, bcd, ovf, valid. The top level holds the display register, scan counter, blanking and decode.

## Test plan
- Reset → `ready`=1, `anode`=4'b0111, `led_out`=7'b0000001 on every digit over a full frame (use SCAN_DIV=4 in sim).
- Load 1234, `blank_lz`=0 → `ready` low 14 cycles. Then digits MSB→LSB show 1001111, 0010010, 0000110, 1001100.
- Load 7, `blank_lz`=1 → three blank digits (1111111), then "7" (0001111). Load 0 → "0" on digit 0 only.
- NUM_W=14, load 12000 → all digits show 1111110. Load during SHIFT → ignored, and the final display matches the first value.
- Reset asserted at cycle 5 of a conversion of 4321 → old display retained as "0000", `ready`=1 immediately, and 4321 never appears.
- `SSD_SIGNED_EN`, load −42 (13'h1FD6), `blank_lz`=1 → blank, minus, "4", "2". Load −1000 → dashes.
